cnu_msg_gen: RTL
================

# cnu_msg_gen

Edge-serial check-to-variable message generator for the min-sum check node unit. It sits directly downstream of the min/second-min finder and captures one check row's compressed state: min, min2, one-hot min index and the incoming sign vector. It then emits the D outgoing messages one edge per cycle over a valid/ready interface. Offset min-sum correction and the sign product are applied here.

## Interface
- `data_w`, 9: magnitude width of min/min2 and of output magnitude
- `D`, 7: check node degree (edges per row), 2..16
- `OFFSET`, 1: offset subtracted from selected magnitude, saturating at 0
- localparam `idx_w` = $clog2(D): edge index width
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset, synchronous, active-high
- `ld_vld`  in  1  row state valid
- `ld_rdy`  out  1  block can accept a row
- `min`  in  data_w  smallest incoming magnitude
- `min2`  in  data_w  second-smallest incoming magnitude
- `min_idx`  in  D  one-hot position of min (all-zero allowed)
- `sign_in`  in  D  incoming message sign per edge (1 = negative)
- `out_vld`  out  1  outgoing message valid
- `out_rdy`  in  1  consumer accepts message
- `out_mag`  out  data_w  outgoing magnitude
- `out_sign`  out  1  outgoing sign
- `out_edge`  out  idx_w  edge index of current message, 0..D-1

## Operation
- Load handshake: row accepted when `ld_vld && ld_rdy` at a clock edge. On acceptance, latch `min`, `min2`, `min_idx` and `sign_in`, and compute `par` = XOR of all `sign_in` bits.
- `ld_rdy` = (state==IDLE) || (state==EMIT && out_vld && out_rdy && out_edge==D-1). It is combinational from state and `out_rdy`.
- States:
  - IDLE → EMIT on load.
  - EMIT, last edge transferred: → EMIT if a simultaneous load occurs, else → IDLE.
- Edge counter `e`: set to 0 on load; increments on each output transfer (`out_vld && out_rdy`) while e < D-1.
- Per-edge message for edge e:
  - sel = min_idx[e] ? min2 : min
  - out_mag = (sel > OFFSET) ? sel - OFFSET : 0, unsigned, no wrap
  - out_sign = par ^ sign_in[e] (extrinsic sign product)
- All-zero `min_idx`: every edge uses min. Multiple bits set: each set edge uses min2. No error is flagged.
- Output registers (`out_mag`, `out_sign`, `out_edge`) are loaded with the message for the new e on load and on each non-final transfer. They hold when `out_vld && !out_rdy`.
- `ld_vld` while `ld_rdy`=0 is ignored. The upstream stage holds its data.

## Timing
- Reset: state IDLE, `out_vld`=0, `out_mag`=0, `out_sign`=0, `out_edge`=0, e=0, latched row state cleared. `ld_rdy`=1 from the cycle after reset.
- Load at edge t → `out_vld`=1 with edge 0 from t+1.
- With `out_rdy` held high, edges 0..D-1 appear on consecutive cycles. Throughput is one row per D cycles, with no bubble when the next load coincides with the transfer of edge D-1.
- After the last transfer with no new load, `out_vld`=0 on the following cycle.
- `rst` mid-emission: remaining edges are discarded and all outputs return to reset values on the next cycle. No partial row survives.
- Output data is stable while `out_vld && !out_rdy`.

## Test plan
- D=7, OFFSET=1; load min=5, min2=9, min_idx=7'b0000100, sign_in=7'b0000011, `out_rdy`=1 → edges 0..6 on consecutive cycles:
  - mags 4,4,8,4,4,4,4
  - signs 1,1,0,0,0,0,0
  - `out_edge` 0..6
  - `out_vld` drops after edge 6.
- Saturation: min=0, min2=1, min_idx=7'b0000001, sign_in=7'b0000001 (par=1) → edge 0 mag 0 sign 0; edges 1..6 mag 0 sign 1.
- Backpressure: same row as the first test; `out_rdy` low for 3 cycles at edge 2 → edge 2 (mag 8) held stable, `ld_rdy`=0 throughout, then edges 3..6 follow.
- Back-to-back: second row (min=2, min2=3, min_idx=7'b1000000, sign_in=0) presented during edge 6 of the first → `ld_rdy`=1 that cycle; next cycle edge 0 of the new row (mag 1, sign 0); edge 6 of the new row has mag 2.
- Zero one-hot: min=7, min2=12, min_idx=0 → all 7 edges mag 6.
- Reset at edge 3 → next cycle `out_vld`=0, all outputs 0, `ld_rdy`=1; a fresh load then restarts cleanly at edge 0.

Source files
------------

// File: rtl/cnu_msg_gen_if.sv
// Row-load and edge-message handshake bundle for the check-to-variable message generator.
interface cnu_msg_gen_if #(
   parameter int data_w = 9,
   parameter int D      = 7
);
   localparam int idx_w = $clog2(D);

   logic              ld_vld;
   logic              ld_rdy;
   logic [data_w-1:0] min;
   logic [data_w-1:0] min2;
   logic [D-1:0]      min_idx;
   logic [D-1:0]      sign_in;
   logic              out_vld;
   logic              out_rdy;
   logic [data_w-1:0] out_mag;
   logic              out_sign;
   logic [idx_w-1:0]  out_edge;

   modport master (
      output ld_vld, min, min2, min_idx, sign_in, out_rdy,
      input  ld_rdy, out_vld, out_mag, out_sign, out_edge
   );

   modport slave (
      input  ld_vld, min, min2, min_idx, sign_in, out_rdy,
      output ld_rdy, out_vld, out_mag, out_sign, out_edge
   );
endinterface

// File: rtl/cnu_msg_gen.sv
// Edge-serial min-sum check-to-variable message generator: latches one row's
// compressed state and emits D offset-corrected, sign-corrected messages.
module cnu_msg_gen #(
   parameter int data_w = 9,
   parameter int D      = 7,
   parameter int OFFSET = 1
) (
   input logic          clk,
   input logic          rst,
   cnu_msg_gen_if.slave bus
);
   localparam int idx_w = $clog2(D);

   typedef enum logic {IDLE, EMIT} state_t;
   state_t state, state_nxt;

   logic [data_w-1:0] min_q, min2_q;
   logic [D-1:0]      idx_q, sign_q;
   logic              par_q;
   logic [idx_w-1:0]  e, e_nxt;
   logic [data_w-1:0] mag_q;
   logic              sign_o;
   logic [idx_w-1:0]  edge_q;

   logic              ld_fire, xfer, last;
   logic [data_w-1:0] mag_ld, mag_adv;
   logic              sign_ld, sign_adv;

   function automatic logic [data_w-1:0] offset_mag(input logic [data_w-1:0] sel);
      return (sel > data_w'(OFFSET)) ? sel - data_w'(OFFSET) : '0;
   endfunction

   // Edge 0 is built straight from the incoming row so it is ready the cycle after load.
   always_comb begin
      e_nxt    = e + idx_w'(1);
      mag_ld   = offset_mag(bus.min_idx[0] ? bus.min2 : bus.min);
      sign_ld  = (^bus.sign_in) ^ bus.sign_in[0];
      mag_adv  = offset_mag(idx_q[e_nxt] ? min2_q : min_q);
      sign_adv = par_q ^ sign_q[e_nxt];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (ld_fire) state_nxt = EMIT;
         EMIT: if (xfer && last) state_nxt = ld_fire ? EMIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      last         = (e == idx_w'(D - 1));
      bus.out_vld  = (state == EMIT);
      xfer         = bus.out_vld && bus.out_rdy;
      bus.ld_rdy   = (state == IDLE) || (state == EMIT && bus.out_rdy && last);
      ld_fire      = bus.ld_vld && bus.ld_rdy;
      bus.out_mag  = mag_q;
      bus.out_sign = sign_o;
      bus.out_edge = edge_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q  <= '0;
         min2_q <= '0;
         idx_q  <= '0;
         sign_q <= '0;
         par_q  <= 1'b0;
         e      <= '0;
         mag_q  <= '0;
         sign_o <= 1'b0;
         edge_q <= '0;
      end else if (ld_fire) begin
         min_q  <= bus.min;
         min2_q <= bus.min2;
         idx_q  <= bus.min_idx;
         sign_q <= bus.sign_in;
         par_q  <= ^bus.sign_in;
         e      <= '0;
         mag_q  <= mag_ld;
         sign_o <= sign_ld;
         edge_q <= '0;
      end else if (xfer && !last) begin
         e      <= e_nxt;
         mag_q  <= mag_adv;
         sign_o <= sign_adv;
         edge_q <= e_nxt;
      end
   end
endmodule
